// File: rtl/rr_mux8to1_collector.sv
// Merges eight valid/ready producer channels into one registered output slot using round-robin arbitration.
// Latency is 1 cycle; the slot refills in the same cycle it drains, and in_ready stays low while the slot is FULL and stalled.
module rr_mux8to1_collector #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_valid,
    input  logic [8*DATA_W-1:0]   in_data,
    output logic [7:0]            in_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [2:0]            out_sel,
    input  logic                  out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    slot_e             state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [2:0]        sel_q, sel_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        grant;
    logic [2:0]        idx;
    logic              found;
    logic              load;

    // First requester at or after rr_ptr, scanning upward with wrap.
    always_comb begin
        grant = 3'd0;
        found = 1'b0;
        idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!found && in_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    // Reset is included so no grant leaks out while rst is held.
    assign load = (state_q == EMPTY || out_ready) && found && !rst;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        sel_d    = sel_q;
        ptr_d    = ptr_q;
        in_ready = 8'h00;
        case (state_q)
            EMPTY:   if (load) state_d = FULL;
            FULL:    if (out_ready && !load) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (load) begin
            data_d   = in_data[grant*DATA_W +: DATA_W];
            sel_d    = grant;
            ptr_d    = grant + 3'd1;
            in_ready = 8'(1) << grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_mux8to1_collector.sv
// Directed and randomized checks of the 8:1 round-robin collector.
module tb_rr_mux8to1_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_valid = 8'h00;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  out_sel;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    rr_mux8to1_collector #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sel  (out_sel),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        in_valid = 8'h00;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #1;
        in_valid = 8'hFF;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sel !== 3'd0 || out_data !== 8'h00 || in_ready !== 8'h00) begin
            errors++;
            $display("FAIL reset_initial valid=%b sel=%0d data=%h rdy=%h want 0/0/00/00", out_valid, out_sel, out_data, in_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'hC0 + 8'(i);
        #1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 3'd0) begin
            errors++;
            $display("FAIL reset_preload valid=%b sel=%0d want 1/0", out_valid, out_sel);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sel !== 3'd0 || out_data !== 8'h00 || in_ready !== 8'h00) begin
            errors++;
            $display("FAIL reset_midstream valid=%b sel=%0d data=%h rdy=%h want 0/0/00/00", out_valid, out_sel, out_data, in_ready);
        end
        tick();
        rst = 1'b0;
        in_valid = 8'h08;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 8'h08) begin
            errors++;
            $display("FAIL reset_grant3 in_ready=%h want 08", in_ready);
        end
        tick();
        in_valid = 8'h00;
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 3'd3 || out_data !== 8'hC3) begin
            errors++;
            $display("FAIL reset_out3 valid=%b sel=%0d data=%h want 1/3/c3", out_valid, out_sel, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'hA0 + 8'(i);
        in_valid = 8'hFF;
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            #1;
            checks++;
            if (in_ready !== (8'h01 << (k % 8))) begin
                errors++;
                $display("FAIL rr_grant step=%0d in_ready=%h want %h", k, in_ready, 8'h01 << (k % 8));
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_sel !== 3'(k % 8) || out_data !== 8'hA0 + 8'(k % 8)) begin
                errors++;
                $display("FAIL rr_out step=%0d valid=%b sel=%0d data=%h want 1/%0d/%h",
                         k, out_valid, out_sel, out_data, k % 8, 8'hA0 + 8'(k % 8));
            end
        end
        in_valid = 8'h00;
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'hA0 + 8'(i);
        in_data[2*8 +: 8] = 8'h55;
        in_valid = 8'h04;
        out_ready = 1'b1;
        tick();
        in_valid = 8'hFF;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (in_ready !== 8'h00) begin
                errors++;
                $display("FAIL stall_ready cycle=%0d in_ready=%h want 00", c, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h55 || out_sel !== 3'd2) begin
                errors++;
                $display("FAIL stall_hold cycle=%0d valid=%b data=%h sel=%0d want 1/55/2", c, out_valid, out_data, out_sel);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 8'h08) begin
            errors++;
            $display("FAIL stall_resume in_ready=%h want 08", in_ready);
        end
        tick();
        in_valid = 8'h00;
        checks++;
        if (out_sel !== 3'd3 || out_data !== 8'hA3) begin
            errors++;
            $display("FAIL stall_next sel=%0d data=%h want 3/a3", out_sel, out_data);
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'hB0 + 8'(i);
        in_valid = 8'h40;
        out_ready = 1'b1;
        tick();
        in_valid = 8'h81;
        #1;
        checks++;
        if (in_ready !== 8'h80) begin
            errors++;
            $display("FAIL wrap_grant7 in_ready=%h want 80", in_ready);
        end
        tick();
        in_valid = 8'h01;
        #1;
        checks++;
        if (out_sel !== 3'd7 || out_data !== 8'hB7 || in_ready !== 8'h01) begin
            errors++;
            $display("FAIL wrap_then0 sel=%0d data=%h in_ready=%h want 7/b7/01", out_sel, out_data, in_ready);
        end
        tick();
        in_valid = 8'h80;
        #1;
        checks++;
        if (out_sel !== 3'd0 || in_ready !== 8'h80) begin
            errors++;
            $display("FAIL wrap_only7 sel=%0d in_ready=%h want 0/80", out_sel, in_ready);
        end
        tick();
        in_valid = 8'h00;
        checks++;
        if (out_sel !== 3'd7 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_out7 sel=%0d valid=%b want 7/1", out_sel, out_valid);
        end
        tick();
    endtask

    task automatic test_sparse();
        do_reset();
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'hD0 + 8'(i);
        in_valid = 8'h04;
        out_ready = 1'b1;
        tick();
        in_valid = 8'h24;
        #1;
        checks++;
        if (in_ready !== 8'h20) begin
            errors++;
            $display("FAIL sparse_grant5 in_ready=%h want 20", in_ready);
        end
        tick();
        in_valid = 8'h00;
        #1;
        checks++;
        if (out_sel !== 3'd5 || out_data !== 8'hD5 || in_ready !== 8'h00) begin
            errors++;
            $display("FAIL sparse_out5 sel=%0d data=%h in_ready=%h want 5/d5/00", out_sel, out_data, in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL sparse_withdrawn cycle=%0d valid=%b sel=%0d want 0", c, out_valid, out_sel);
            end
        end
    endtask

    task automatic test_random();
        logic [10:0] exp_q[$];
        logic [10:0] e;
        logic [4:0]  seq [8];
        int          wait_cnt [8];
        int          drain;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            seq[i] = 5'd0;
            wait_cnt[i] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < 8; i++) begin
                if (!in_valid[i] && ($urandom_range(0, 2) == 0)) begin
                    in_valid[i] = 1'b1;
                    in_data[i*8 +: 8] = {3'(i), seq[i]};
                    seq[i] = seq[i] + 5'd1;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if ($countones(in_ready) > 1 || (in_ready & ~in_valid) != 8'h00) begin
                checks++;
                errors++;
                $display("FAIL rand_onehot cyc=%0d in_ready=%h in_valid=%h", cyc, in_ready, in_valid);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_dup cyc=%0d sel=%0d data=%h want none", cyc, out_sel, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_sel, out_data} !== e) begin
                        errors++;
                        $display("FAIL rand_word cyc=%0d sel=%0d data=%h want %0d/%h", cyc, out_sel, out_data, e[10:8], e[7:0]);
                    end
                end
            end
            if (in_ready != 8'h00) begin
                for (int i = 0; i < 8; i++) begin
                    if (in_valid[i] && in_ready[i]) begin
                        exp_q.push_back({3'(i), in_data[i*8 +: 8]});
                        checks++;
                        if (wait_cnt[i] > 7) begin
                            errors++;
                            $display("FAIL rand_fair ch=%0d waited %0d loads want <=7", i, wait_cnt[i]);
                        end
                        wait_cnt[i] = 0;
                    end else if (in_valid[i]) begin
                        wait_cnt[i]++;
                    end
                end
            end
            tick();
            for (int i = 0; i < 8; i++)
                if (in_valid[i] && exp_q.size() > 0 && out_valid && out_sel == 3'(i)
                    && out_data == in_data[i*8 +: 8] && exp_q[exp_q.size()-1] == {3'(i), in_data[i*8 +: 8]})
                    in_valid[i] = 1'b0;
        end
        in_valid = 8'h00;
        out_ready = 1'b1;
        drain = 0;
        while (exp_q.size() > 0 && drain < 20) begin
            #1;
            if (out_valid) begin
                e = exp_q.pop_front();
                checks++;
                if ({out_sel, out_data} !== e) begin
                    errors++;
                    $display("FAIL rand_drain sel=%0d data=%h want %0d/%h", out_sel, out_data, e[10:8], e[7:0]);
                end
            end
            tick();
            drain++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_loss pending=%0d valid=%b want 0/0", exp_q.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_stall();
        test_wrap();
        test_sparse();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
